// File: rtl/fht_mem_pkg.sv
// fht_mem_pkg: shared sizes and types for the FHT ping-pong bank storage.
package fht_mem_pkg;
    localparam int BANKS  = 4;
    localparam int A_BIT  = 8;
    localparam int D_BIT  = 16;
    localparam int RD_LAT = 2;
    typedef logic [A_BIT-1:0] addr_t;
    typedef logic [D_BIT-1:0] data_t;
    typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;
endpackage

// File: rtl/fht_ram_1r1w.sv
// fht_ram_1r1w: one bank, one write port and one registered read-first read port.
module fht_ram_1r1w
    import fht_mem_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  logic  re,
    input  addr_t raddr,
    output data_t rdata
);
    data_t mem [2**A_BIT];
    data_t rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/fht_mem_bank.sv
// fht_mem_bank: two 4-lane bank sets (A/B) with a 2-cycle read pipeline and set mux.
// Define FHT_MEM_BYPASS_EN for write-first forwarding on same-lane address collisions.
module fht_mem_bank
    import fht_mem_pkg::*;
(
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iRD_EN,
    input  logic             iSOURCE_DATA,
    input  logic [A_BIT-1:0] iADDR_RD_0,
    input  logic [A_BIT-1:0] iADDR_RD_1,
    input  logic [A_BIT-1:0] iADDR_RD_2,
    input  logic [A_BIT-1:0] iADDR_RD_3,
    input  logic [A_BIT-1:0] iADDR_WR_0,
    input  logic [A_BIT-1:0] iADDR_WR_1,
    input  logic [A_BIT-1:0] iADDR_WR_2,
    input  logic [A_BIT-1:0] iADDR_WR_3,
    input  logic [D_BIT-1:0] iDATA_0,
    input  logic [D_BIT-1:0] iDATA_1,
    input  logic [D_BIT-1:0] iDATA_2,
    input  logic [D_BIT-1:0] iDATA_3,
    input  logic             iWE_A,
    input  logic             iWE_B,
    output logic [D_BIT-1:0] oDATA_0,
    output logic [D_BIT-1:0] oDATA_1,
    output logic [D_BIT-1:0] oDATA_2,
    output logic [D_BIT-1:0] oDATA_3,
    output logic             oVALID
);
    addr_t rd_addr [BANKS];
    addr_t wr_addr [BANKS];
    data_t wdata   [BANKS];
    data_t q_a     [BANKS];
    data_t q_b     [BANKS];
    logic  we_a, we_b;
    logic [RD_LAT-1:0] vld_d, vld_q;
    src_t  src_d, src_q;
    data_t data_d [BANKS];
    data_t data_q [BANKS];
    data_t sel;
`ifdef FHT_MEM_BYPASS_EN
    logic [BANKS-1:0] hit_d, hit_q;
    data_t fwd_d   [BANKS];
    data_t fwd_q   [BANKS];
    addr_t raddr_d [BANKS];
    addr_t raddr_q [BANKS];
    logic  we_s0, we_s1;
`endif
    assign rd_addr = '{iADDR_RD_0, iADDR_RD_1, iADDR_RD_2, iADDR_RD_3};
    assign wr_addr = '{iADDR_WR_0, iADDR_WR_1, iADDR_WR_2, iADDR_WR_3};
    assign wdata   = '{iDATA_0, iDATA_1, iDATA_2, iDATA_3};
    // Writes seen while reset is held must not touch the banks.
    assign we_a = iWE_A & iRESET;
    assign we_b = iWE_B & iRESET;
    for (genvar k = 0; k < BANKS; k++) begin : g_lane
        fht_ram_1r1w u_ram_a (
            .clk(iCLK), .we(we_a), .waddr(wr_addr[k]), .wdata(wdata[k]),
            .re(iRD_EN), .raddr(rd_addr[k]), .rdata(q_a[k])
        );
        fht_ram_1r1w u_ram_b (
            .clk(iCLK), .we(we_b), .waddr(wr_addr[k]), .wdata(wdata[k]),
            .re(iRD_EN), .raddr(rd_addr[k]), .rdata(q_b[k])
        );
    end
    always_comb begin
        vld_d  = {vld_q[RD_LAT-2:0], iRD_EN};
        src_d  = src_t'(iSOURCE_DATA);
        data_d = data_q;
        sel    = '0;
`ifdef FHT_MEM_BYPASS_EN
        hit_d   = '0;
        fwd_d   = wdata;
        raddr_d = rd_addr;
        we_s0   = iSOURCE_DATA ? we_b : we_a;
        we_s1   = (src_q == SRC_B) ? we_b : we_a;
`endif
        for (int i = 0; i < BANKS; i++) begin
            sel = (src_q == SRC_B) ? q_b[i] : q_a[i];
`ifdef FHT_MEM_BYPASS_EN
            hit_d[i] = iRD_EN && we_s0 && (wr_addr[i] == rd_addr[i]);
            // A write landing at the stage-1 edge is newer than one captured at stage 0.
            sel = (we_s1 && raddr_q[i] == wr_addr[i]) ? wdata[i] : hit_q[i] ? fwd_q[i] : sel;
`endif
            data_d[i] = vld_q[0] ? sel : data_q[i];
        end
    end
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            vld_q  <= '0;
            src_q  <= SRC_A;
            data_q <= '{default: '0};
`ifdef FHT_MEM_BYPASS_EN
            hit_q   <= '0;
            fwd_q   <= '{default: '0};
            raddr_q <= '{default: '0};
`endif
        end else begin
            vld_q  <= vld_d;
            src_q  <= src_d;
            data_q <= data_d;
`ifdef FHT_MEM_BYPASS_EN
            hit_q   <= hit_d;
            fwd_q   <= fwd_d;
            raddr_q <= raddr_d;
`endif
        end
    end
    assign oDATA_0 = data_q[0];
    assign oDATA_1 = data_q[1];
    assign oDATA_2 = data_q[2];
    assign oDATA_3 = data_q[3];
    assign oVALID  = vld_q[RD_LAT-1];
endmodule

// File: tb/tb_fht_mem_bank.sv
// tb_fht_mem_bank: directed self-checking bench for fht_mem_bank.
module tb_fht_mem_bank;
    logic        iCLK = 1'b0;
    logic        iRESET, iRD_EN, iSOURCE_DATA, iWE_A, iWE_B;
    logic [7:0]  iADDR_RD_0, iADDR_RD_1, iADDR_RD_2, iADDR_RD_3;
    logic [7:0]  iADDR_WR_0, iADDR_WR_1, iADDR_WR_2, iADDR_WR_3;
    logic [15:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3;
    logic [15:0] oDATA_0, oDATA_1, oDATA_2, oDATA_3;
    logic        oVALID;
    int total = 0;
    int bad = 0;
    int vcount;
    logic [15:0] col_exp;

    fht_mem_bank dut (
        .iCLK(iCLK), .iRESET(iRESET), .iRD_EN(iRD_EN), .iSOURCE_DATA(iSOURCE_DATA),
        .iADDR_RD_0(iADDR_RD_0), .iADDR_RD_1(iADDR_RD_1), .iADDR_RD_2(iADDR_RD_2), .iADDR_RD_3(iADDR_RD_3),
        .iADDR_WR_0(iADDR_WR_0), .iADDR_WR_1(iADDR_WR_1), .iADDR_WR_2(iADDR_WR_2), .iADDR_WR_3(iADDR_WR_3),
        .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iDATA_2(iDATA_2), .iDATA_3(iDATA_3),
        .iWE_A(iWE_A), .iWE_B(iWE_B),
        .oDATA_0(oDATA_0), .oDATA_1(oDATA_1), .oDATA_2(oDATA_2), .oDATA_3(oDATA_3),
        .oVALID(oVALID)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic en, input logic src, input logic [7:0] a);
        iRD_EN = en;
        iSOURCE_DATA = src;
        {iADDR_RD_0, iADDR_RD_1, iADDR_RD_2, iADDR_RD_3} = {a, a, a, a};
    endtask

    task automatic set_wr(input logic wa, input logic wb, input logic [7:0] a,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
        iWE_A = wa;
        iWE_B = wb;
        {iADDR_WR_0, iADDR_WR_1, iADDR_WR_2, iADDR_WR_3} = {a, a, a, a};
        {iDATA_0, iDATA_1, iDATA_2, iDATA_3} = {d0, d1, d2, d3};
    endtask

    initial begin
`ifdef FHT_MEM_BYPASS_EN
        col_exp = 16'h00FF;
`else
        col_exp = 16'h0001;
`endif
        iRESET = 1'b0;
        set_rd(1'b0, 1'b0, 8'd0);
        set_wr(1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        repeat (3) tick();
        chk("rst_valid", {15'd0, oVALID}, 16'd0);
        chk("rst_d0", oDATA_0, 16'd0);
        chk("rst_d3", oDATA_3, 16'd0);
        iRESET = 1'b1;
        repeat (3) tick();
        chk("idle_valid", {15'd0, oVALID}, 16'd0);
        chk("idle_d1", oDATA_1, 16'd0);

        // broadcast load, then read A and B back to back
        set_wr(1'b1, 1'b1, 8'd5, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        tick();
        set_wr(1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        set_rd(1'b1, 1'b0, 8'd5);
        tick();
        chk("bc_pre_valid", {15'd0, oVALID}, 16'd0);
        set_rd(1'b1, 1'b1, 8'd5);
        tick();
        chk("bcA_valid", {15'd0, oVALID}, 16'd1);
        chk("bcA_d0", oDATA_0, 16'h1111);
        chk("bcA_d1", oDATA_1, 16'h2222);
        chk("bcA_d2", oDATA_2, 16'h3333);
        chk("bcA_d3", oDATA_3, 16'h4444);
        set_rd(1'b0, 1'b0, 8'd0);
        tick();
        chk("bcB_valid", {15'd0, oVALID}, 16'd1);
        chk("bcB_d0", oDATA_0, 16'h1111);
        chk("bcB_d3", oDATA_3, 16'h4444);
        tick();
        chk("hold_valid", {15'd0, oVALID}, 16'd0);
        chk("hold_d2", oDATA_2, 16'h3333);

        // ping-pong isolation
        set_wr(1'b1, 1'b0, 8'd7, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        tick();
        set_wr(1'b0, 1'b1, 8'd7, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
        tick();
        set_wr(1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        set_rd(1'b1, 1'b0, 8'd7);
        tick();
        set_rd(1'b1, 1'b1, 8'd7);
        tick();
        chk("pp0_d0", oDATA_0, 16'hAAAA);
        set_rd(1'b1, 1'b0, 8'd7);
        tick();
        chk("pp1_d0", oDATA_0, 16'h5555);
        chk("pp1_d3", oDATA_3, 16'h5555);
        set_rd(1'b0, 1'b0, 8'd0);
        tick();
        chk("pp2_d0", oDATA_0, 16'hAAAA);
        chk("pp2_valid", {15'd0, oVALID}, 16'd1);

        // read/write collision on set A addr 3
        set_wr(1'b1, 1'b0, 8'd3, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
        tick();
        set_wr(1'b1, 1'b0, 8'd3, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF);
        set_rd(1'b1, 1'b0, 8'd3);
        tick();
        set_wr(1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        set_rd(1'b1, 1'b0, 8'd3);
        tick();
        chk("col_d0", oDATA_0, col_exp);
        chk("col_d2", oDATA_2, col_exp);
        set_rd(1'b0, 1'b0, 8'd0);
        tick();
        chk("col_reread_d0", oDATA_0, 16'h00FF);

        // mid-read reset; a write during reset must be dropped
        set_rd(1'b1, 1'b1, 8'd7);
        tick();
        iRESET = 1'b0;
        set_rd(1'b0, 1'b0, 8'd0);
        set_wr(1'b0, 1'b1, 8'd7, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
        tick();
        iRESET = 1'b1;
        set_wr(1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        chk("mrst_valid0", {15'd0, oVALID}, 16'd0);
        chk("mrst_d0", oDATA_0, 16'd0);
        tick();
        chk("mrst_valid1", {15'd0, oVALID}, 16'd0);
        set_rd(1'b1, 1'b1, 8'd7);
        tick();
        set_rd(1'b0, 1'b0, 8'd0);
        tick();
        chk("mrst_reread_valid", {15'd0, oVALID}, 16'd1);
        chk("mrst_reread_d1", oDATA_1, 16'h5555);

        // full sweep of set B
        for (int a = 0; a < 256; a++) begin
            set_wr(1'b0, 1'b1, 8'(a), 16'h1000 ^ 16'(a), 16'h2000 ^ 16'(a * 3),
                   16'h4000 ^ 16'(a * 5), 16'h8000 ^ 16'(255 - a));
            tick();
        end
        set_wr(1'b0, 1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        vcount = 0;
        for (int i = 0; i < 258; i++) begin
            if (i < 256) set_rd(1'b1, 1'b1, 8'(i));
            else set_rd(1'b0, 1'b0, 8'd0);
            tick();
            if (oVALID) vcount++;
            if (i >= 1 && i <= 256) begin
                chk("sw_valid", {15'd0, oVALID}, 16'd1);
                chk("sw_d0", oDATA_0, 16'h1000 ^ 16'(i - 1));
                chk("sw_d1", oDATA_1, 16'h2000 ^ 16'((i - 1) * 3));
                chk("sw_d2", oDATA_2, 16'h4000 ^ 16'((i - 1) * 5));
                chk("sw_d3", oDATA_3, 16'h8000 ^ 16'(256 - i));
            end
        end
        chk("sw_vcount", 16'(vcount), 16'd256);
        tick();
        chk("sw_end_valid", {15'd0, oVALID}, 16'd0);

        // set A untouched by the set-B sweep
        set_rd(1'b1, 1'b0, 8'd5);
        tick();
        set_rd(1'b0, 1'b0, 8'd0);
        tick();
        chk("iso_d0", oDATA_0, 16'h1111);
        chk("iso_d3", oDATA_3, 16'h4444);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
